alu_exec_unit: RTL and testbench

//  Parametrised EX-stage integer unit. Decodes ALUOp/funct internally and executes

---
 rtl/alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage integer unit: single-cycle ALU ops plus iterative MULTU/DIVU.
// HI/LO are architectural registers written only when a mul/div completes.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             invalid_op,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    typedef enum logic [1:0] {
        K_ALU,
        K_MUL,
        K_DIV,
        K_DZ
    } kind_t;

    state_t state;
    state_t state_next;
    kind_t  kind;

    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic             sltu;
    logic [WIDTH-1:0] dec_res;
    logic             dec_ovf;
    logic             dec_inv;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last_iter;

    assign in_ready  = (state == S_IDLE) & ~reset;
    assign accept    = in_valid & in_ready;
    assign last_iter = (state != S_IDLE) & (cnt == LAST);

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                     (sum[WIDTH-1] != op_a[WIDTH-1]);
    assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) &
                     (diff[WIDTH-1] != op_a[WIDTH-1]);
    assign slt     = $signed(op_a) < $signed(op_b);
    assign sltu    = op_a < op_b;

    // Decode alu_op/funct into an op class and the single-cycle result
    always_comb begin
        kind    = K_ALU;
        dec_res = '0;
        dec_ovf = 1'b0;
        dec_inv = 1'b0;
        case (alu_op)
            2'b00: begin
                dec_res = sum;
                dec_ovf = add_ovf;
            end
            2'b01: begin
                dec_res = diff;
                dec_ovf = sub_ovf;
            end
            2'b10: begin
                case (funct)
                    6'b100000: begin
                        dec_res = sum;
                        dec_ovf = add_ovf;
                    end
                    6'b100001: dec_res = sum;
                    6'b100010: begin
                        dec_res = diff;
                        dec_ovf = sub_ovf;
                    end
                    6'b100011: dec_res = diff;
                    6'b100100: dec_res = op_a & op_b;
                    6'b100101: dec_res = op_a | op_b;
                    6'b100110: dec_res = op_a ^ op_b;
                    6'b100111: dec_res = ~(op_a | op_b);
                    6'b101010: dec_res = {{(WIDTH-1){1'b0}}, slt};
                    6'b101011: dec_res = {{(WIDTH-1){1'b0}}, sltu};
                    6'b011001: kind = K_MUL;
                    6'b011011: begin
                        if (DIV_EN) begin
                            kind = (op_b == '0) ? K_DZ : K_DIV;
                        end else begin
                            dec_inv = 1'b1;
                        end
                    end
                    6'b010000: dec_res = hi;
                    6'b010010: dec_res = lo;
                    default:   dec_inv = 1'b1;
                endcase
            end
            default: dec_inv = 1'b1;
        endcase
    end

    // One shift-add or restoring-divide step on the shared accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs};
        div_ge    = div_shift >= {1'b0, dvs};
        step_hi   = '0;
        step_lo   = '0;
        if (state == S_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on mul/div accept, return after the last step
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && kind == K_MUL) begin
                    state_next = S_MUL;
                end else if (accept && kind == K_DIV) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Result/flag registers, iteration datapath and HI/LO updates
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            invalid_op  <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            dvs         <= '0;
        end else begin
            out_valid   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            invalid_op  <= 1'b0;
            div_by_zero <= 1'b0;
            if (accept) begin
                case (kind)
                    K_ALU: begin
                        out_valid  <= 1'b1;
                        result     <= dec_res;
                        zero       <= (dec_res == '0) & ~dec_inv;
                        overflow   <= dec_ovf;
                        invalid_op <= dec_inv;
                    end
                    K_MUL, K_DIV: begin
                        acc_hi <= '0;
                        acc_lo <= op_a;
                        dvs    <= op_b;
                        cnt    <= '0;
                    end
                    K_DZ: begin
                        out_valid   <= 1'b1;
                        result      <= '0;
                        zero        <= 1'b1;
                        div_by_zero <= 1'b1;
                        hi          <= op_a;
                        lo          <= '1;
                    end
                    default: ;
                endcase
            end
            if (state != S_IDLE) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    hi        <= step_hi;
                    lo        <= step_lo;
                    out_valid <= 1'b1;
                    result    <= '0;
                    zero      <= 1'b1;
                    cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a 32-bit instance with DIVU and an
// 8-bit instance without it, sharing clock and reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        invalid_op;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [1:0]  alu_op8 = 2'b00;
    logic [5:0]  funct8 = 6'b0;
    logic [7:0]  op_a8 = '0;
    logic [7:0]  op_b8 = '0;
    logic        out_valid8;
    logic [7:0]  result8;
    logic        zero8;
    logic        overflow8;
    logic        invalid_op8;
    logic        div_by_zero8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .result(result),
        .zero(zero), .overflow(overflow),
        .invalid_op(invalid_op), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    alu_exec_unit #(.WIDTH(8), .DIV_EN(1'b0)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op8), .funct(funct8),
        .op_a(op_a8), .op_b(op_b8),
        .out_valid(out_valid8), .result(result8),
        .zero(zero8), .overflow(overflow8),
        .invalid_op(invalid_op8), .div_by_zero(div_by_zero8),
        .hi(hi8), .lo(lo8)
    );

    // Present one op for one accept edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = f;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [5:0] f,
                          input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid8 = 1'b1;
        alu_op8   = op;
        funct8    = f;
        op_a8     = a;
        op_b8     = b;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        tests++;
        if ({out_valid, result, zero, overflow, invalid_op, div_by_zero} !== '0) begin
            fails++;
            $display("FAIL reset_outputs ov=%b res=%h flags=%b%b%b%b exp=0",
                     out_valid, result, zero, overflow, invalid_op, div_by_zero);
        end
        tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++;
            $display("FAIL reset_hilo hi=%h lo=%h exp=0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got=%b/%b exp=1/1", in_ready, in_ready8);
        end
    endtask

    task automatic test_add();
        issue(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
        tests++;
        if (out_valid !== 1'b1 || result !== 32'h80000000 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL add_ovf ov=%b res=%h ovf=%b exp=1/80000000/1",
                     out_valid, result, overflow);
        end
        issue(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1);
        tests++;
        if (out_valid !== 1'b1 || result !== 32'h80000000 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL addu ov=%b res=%h ovf=%b exp=1/80000000/0",
                     out_valid, result, overflow);
        end
        issue(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h1);
        tests++;
        if (result !== 32'h80000000 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL aluop_add res=%h ovf=%b exp=80000000/1", result, overflow);
        end
        issue(2'b01, 6'b000000, 32'h80000000, 32'h1);
        tests++;
        if (result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
            fails++;
            $display("FAIL aluop_sub res=%h ovf=%b exp=7fffffff/1", result, overflow);
        end
        issue(2'b10, 6'b100011, 32'h3, 32'h5);
        tests++;
        if (result !== 32'hFFFFFFFE || overflow !== 1'b0) begin
            fails++;
            $display("FAIL subu res=%h ovf=%b exp=fffffffe/0", result, overflow);
        end
    endtask

    task automatic test_compare();
        issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
        tests++;
        if (result !== 32'h1 || zero !== 1'b0) begin
            fails++;
            $display("FAIL slt res=%h zero=%b exp=1/0", result, zero);
        end
        issue(2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1);
        tests++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            fails++;
            $display("FAIL sltu res=%h zero=%b exp=0/1", result, zero);
        end
        issue(2'b10, 6'b100010, 32'h5, 32'h5);
        tests++;
        if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL sub_zero res=%h zero=%b ovf=%b exp=0/1/0",
                     result, zero, overflow);
        end
    endtask

    task automatic test_logic();
        logic [5:0]  fs [4];
        logic [31:0] ex [4];
        fs = '{6'b100100, 6'b100101, 6'b100110, 6'b100111};
        ex = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0, 32'h000FF000};
        for (int i = 0; i < 4; i++) begin
            issue(2'b10, fs[i], 32'hF0F000FF, 32'h0FF00F0F);
            tests++;
            if (result !== ex[i]) begin
                fails++;
                $display("FAIL logic_%0d res=%h exp=%h", i, result, ex[i]);
            end
        end
    endtask

    task automatic test_invalid();
        issue(2'b10, 6'b111111, 32'h12, 32'h34);
        tests++;
        if (out_valid !== 1'b1 || invalid_op !== 1'b1 || result !== 32'h0 ||
            zero !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL inv_funct ov=%b inv=%b res=%h zero=%b ovf=%b exp=1/1/0/0/0",
                     out_valid, invalid_op, result, zero, overflow);
        end
        issue(2'b11, 6'b100000, 32'h12, 32'h34);
        tests++;
        if (invalid_op !== 1'b1 || result !== 32'h0) begin
            fails++;
            $display("FAIL inv_aluop inv=%b res=%h exp=1/0", invalid_op, result);
        end
    endtask

    task automatic test_multu();
        int k;
        bit ready_leak;
        issue(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        k = 0;
        ready_leak = 1'b0;
        while (out_valid !== 1'b1 && k < 40) begin
            if (in_ready !== 1'b0) ready_leak = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        tests++;
        if (k != 32 || ready_leak) begin
            fails++;
            $display("FAIL multu_latency cycles=%0d leak=%b exp=32/0", k, ready_leak);
        end
        tests++;
        if (in_ready !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            fails++;
            $display("FAIL multu_done rdy=%b res=%h zero=%b exp=1/0/1",
                     in_ready, result, zero);
        end
        tests++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            fails++;
            $display("FAIL multu_hilo hi=%h lo=%h exp=fffffffe/00000001", hi, lo);
        end
        issue(2'b10, 6'b010000, 32'h0, 32'h0);
        tests++;
        if (out_valid !== 1'b1 || result !== 32'hFFFFFFFE) begin
            fails++;
            $display("FAIL mfhi res=%h exp=fffffffe", result);
        end
        issue(2'b10, 6'b010010, 32'h0, 32'h0);
        tests++;
        if (result !== 32'h00000001) begin
            fails++;
            $display("FAIL mflo res=%h exp=00000001", result);
        end
    endtask

    task automatic test_divu();
        int k;
        issue(2'b10, 6'b011011, 32'd100, 32'd7);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests++;
        if (k != 32 || hi !== 32'd2 || lo !== 32'd14) begin
            fails++;
            $display("FAIL divu cycles=%0d hi=%h lo=%h exp=32/2/e", k, hi, lo);
        end
        issue(2'b10, 6'b011011, 32'd9, 32'd0);
        tests++;
        if (out_valid !== 1'b1 || div_by_zero !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL divu0_flags ov=%b dz=%b rdy=%b exp=1/1/1",
                     out_valid, div_by_zero, in_ready);
        end
        tests++;
        if (hi !== 32'd9 || lo !== 32'hFFFFFFFF || result !== 32'h0) begin
            fails++;
            $display("FAIL divu0_hilo hi=%h lo=%h res=%h exp=9/ffffffff/0", hi, lo, result);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL divu0_clear ov=%b dz=%b exp=0/0", out_valid, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            alu_op   = 2'b10;
            funct    = 6'b100000;
            op_a     = 32'(i + 10);
            op_b     = 32'(i);
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== 32'(2 * i + 10)) begin
                fails++;
                $display("FAIL b2b_%0d ov=%b res=%h exp=1/%h",
                         i, out_valid, result, 32'(2 * i + 10));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle ov=%b zero=%b ovf=%b exp=0/0/0",
                     out_valid, zero, overflow);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        issue(2'b10, 6'b011001, 32'hFFFFFFFF, 32'h3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            fails++;
            $display("FAIL midreset_hold rdy=%b hi=%h lo=%h exp=0/0/0", in_ready, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_ready got=%b exp=1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen || hi !== 32'h0 || lo !== 32'h0) begin
            fails++;
            $display("FAIL midreset_abort seen=%b hi=%h lo=%h exp=0/0/0", seen, hi, lo);
        end
    endtask

    task automatic test_width8();
        int k;
        issue8(2'b10, 6'b011011, 8'd100, 8'd7);
        tests++;
        if (out_valid8 !== 1'b1 || invalid_op8 !== 1'b1 || in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL w8_divu_inv ov=%b inv=%b rdy=%b exp=1/1/1",
                     out_valid8, invalid_op8, in_ready8);
        end
        issue8(2'b10, 6'b011001, 8'hFF, 8'hFF);
        k = 0;
        while (out_valid8 !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests++;
        if (k != 8 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
            fails++;
            $display("FAIL w8_multu cycles=%0d hi=%h lo=%h exp=8/fe/01", k, hi8, lo8);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_compare();
        test_logic();
        test_invalid();
        test_multu();
        test_divu();
        test_back_to_back();
        test_mid_reset();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
